// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit
// Turns one load/store into a req/gnt/rvalid bus access with byte lanes,
// load alignment/extension, fault detection and core stall.
// Rev    : 1.0
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  function_3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        stall_out,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        fault_out,
    output logic [1:0]  fault_cause_out,
    output logic        bus_req_out,
    output logic        bus_we_out,
    output logic [31:0] bus_addr_out,
    output logic [3:0]  bus_be_out,
    output logic [31:0] bus_wdata_out,
    input  logic        bus_gnt_in,
    input  logic        bus_rvalid_in,
    input  logic [31:0] bus_rdata_in
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST     = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0]  CAUSE_ILLEGAL    = 2'b10;
    localparam logic [1:0]  CAUSE_TIMEOUT    = 2'b11;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_cause_q, fault_cause_d;

    logic        access;
    logic        illegal;
    logic        misaligned;
    logic        bus_done;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    assign access    = mem_read_in | mem_write_in;
    assign stall_out = access && (state_q != ST_DONE);

    // Stores have no unsigned variants, so 100/101 are only legal for loads.
    always_comb begin
        illegal = mem_read_in & mem_write_in;
        case (function_3_in)
            3'b000, 3'b001, 3'b010: begin
            end
            3'b100, 3'b101: begin
                if (mem_write_in) begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        misaligned = ((function_3_in[1:0] == 2'b01) && addr_in[0]) ||
                     ((function_3_in[1:0] == 2'b10) && (addr_in[1:0] != 2'b00));
    end

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = store_data_in;
        case (function_3_in[1:0])
            2'b00: begin
                wdata_calc = {4{store_data_in[7:0]}};
                if (mem_write_in) begin
                    be_calc = 4'b0001 << addr_in[1:0];
                end
            end
            2'b01: begin
                wdata_calc = {2{store_data_in[15:0]}};
                if (mem_write_in) begin
                    be_calc = addr_in[1] ? 4'b1100 : 4'b0011;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        rdata_shifted = bus_rdata_in >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_ext = {24'b0, rdata_shifted[7:0]};
            3'b101:  load_ext = {16'b0, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    // A response only counts once the request has been granted.
    assign bus_done = bus_rvalid_in && ((state_q == ST_WAIT) || bus_gnt_in);

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        funct3_d      = funct3_q;
        offset_d      = offset_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        load_data_d   = load_data_q;
        load_valid_d  = 1'b0;
        fault_d       = 1'b0;
        fault_cause_d = 2'b00;
        case (state_q)
            ST_IDLE: begin
                timer_d = 16'd0;
                if (access) begin
                    if (illegal) begin
                        state_d       = ST_DONE;
                        fault_d       = 1'b1;
                        fault_cause_d = CAUSE_ILLEGAL;
                    end else if (misaligned) begin
                        state_d       = ST_DONE;
                        fault_d       = 1'b1;
                        fault_cause_d = CAUSE_MISALIGNED;
                    end else begin
                        state_d     = ST_REQ;
                        funct3_d    = function_3_in;
                        offset_d    = addr_in[1:0];
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write_in;
                        bus_addr_d  = {addr_in[31:2], 2'b00};
                        bus_be_d    = be_calc;
                        bus_wdata_d = wdata_calc;
                    end
                end
            end
            ST_REQ, ST_WAIT: begin
                timer_d = timer_q + 16'd1;
                if (bus_done) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        load_data_d  = load_ext;
                        load_valid_d = 1'b1;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d       = ST_DONE;
                    bus_req_d     = 1'b0;
                    fault_d       = 1'b1;
                    fault_cause_d = CAUSE_TIMEOUT;
                end else if ((state_q == ST_REQ) && bus_gnt_in) begin
                    state_d   = ST_WAIT;
                    bus_req_d = 1'b0;
                end
            end
            default: begin
                timer_d = 16'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            timer_q       <= 16'd0;
            funct3_q      <= 3'b000;
            offset_q      <= 2'b00;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'd0;
            bus_be_q      <= 4'd0;
            bus_wdata_q   <= 32'd0;
            load_data_q   <= 32'd0;
            load_valid_q  <= 1'b0;
            fault_q       <= 1'b0;
            fault_cause_q <= 2'b00;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            funct3_q      <= funct3_d;
            offset_q      <= offset_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            load_data_q   <= load_data_d;
            load_valid_q  <= load_valid_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
        end
    end

    assign bus_req_out     = bus_req_q;
    assign bus_we_out      = bus_we_q;
    assign bus_addr_out    = bus_addr_q;
    assign bus_be_out      = bus_be_q;
    assign bus_wdata_out   = bus_wdata_q;
    assign load_data_out   = load_data_q;
    assign load_valid_out  = load_valid_q;
    assign fault_out       = fault_q;
    assign fault_cause_out = fault_cause_q;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Responder side of the memory-control outputs (mem-read / mem-write, funct3) that the decode/control path generates. It turns a single load or store into a request/grant/response data-bus transaction. It also generates byte enables and store-data replication, and aligns and sign/zero-extends load data. It stalls the single-cycle core until the access completes, faults, or times out.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before the access is aborted with a timeout fault (1..65535).

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
mem_read_in  in  1  load instruction in execute
mem_write_in  in  1  store instruction in execute
function_3_in  in  3  funct3 of the instruction (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101)
addr_in  in  32  effective byte address from the ALU
store_data_in  in  32  rs2 value
stall_out  out  1  holds PC and register file while the access is in progress
load_data_out  out  32  aligned, extended load result
load_valid_out  out  1  one-cycle pulse; load_data_out is valid and may be written back
fault_out  out  1  one-cycle pulse on access fault
fault_cause_out  out  2  00 none, 01 misaligned, 10 illegal funct3 or both read and write, 11 bus timeout
bus_req_out  out  1  request
bus_we_out  out  1  1 = write
bus_addr_out  out  32  word address ({addr_in[31:2],2'b00})
bus_be_out  out  4  byte enables
bus_wdata_out  out  32  replicated store data
bus_gnt_in  in  1  request accepted this cycle
bus_rvalid_in  in  1  response (read data or write ack)
bus_rdata_in  in  32  read data

Behaviour:
- Reset (async, rst_n=0): state IDLE; timeout counter 0.
  - bus_req_out, bus_we_out, bus_addr_out, bus_be_out, bus_wdata_out, load_data_out, load_valid_out, fault_out and fault_cause_out all reset to 0.
  - Reset mid-transaction abandons the access. A late bus_rvalid_in seen in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If mem_read_in|mem_write_in, the access is checked. Faulty access → DONE with fault latched; no bus request. Valid access → latch addr/funct3/we, drive bus outputs, go REQ.
  - Fault priority: illegal (both read and write asserted, or funct3 not listed above) > misaligned.
  - Misaligned means: half access with addr[0]=1; word access with addr[1:0]≠0.
- REQ:
  - bus_req_out=1; bus address, we, be and wdata held stable until gnt.
  - gnt=1 → deassert req next cycle and go WAIT.
  - gnt=1 and rvalid=1 in the same cycle → go DONE directly.
- WAIT: rvalid=1 → capture rdata (loads) and go DONE. Stores also wait for rvalid as the write ack.
- Timeout: the counter increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES-1 without completion: drop req, go DONE with cause 11.
- DONE:
  - One cycle. stall_out=0; load_valid_out=1 for a successful load; fault_out=1 with the latched cause on fault.
  - Next state is IDLE; the counter clears.
- stall_out is combinational: (mem_read_in|mem_write_in) && state≠DONE. It is 1 in the IDLE cycle that accepts an access.
- Byte enables and store data:
  - SB: be=1<<addr[1:0]; wdata={4{rs2[7:0]}}.
  - SH: be=addr[1]?1100:0011; wdata={2{rs2[15:0]}}.
  - SW: be=1111; wdata=rs2.
  - Loads drive be=1111.
- Load extraction:
  - Shift rdata right by addr[1:0]*8.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - load_data_out is registered and holds until the next completed load.
- Outputs in DONE on fault: load_valid_out=0; load_data_out unchanged.

Test Plan:
- LW addr 0x100, gnt at cycle 1, rvalid at cycle 3 with rdata 0xDEADBEEF → bus_addr 0x100, be 1111; stall high 4 cycles; load_valid pulse; load_data 0xDEADBEEF.
- LB addr 0x203 with rdata 0x80FF_0000 → load_data 0xFFFFFF80. LBU at the same address → 0x00000080. LHU addr 0x202 → 0x000080FF.
- SB addr 0x11, rs2 0x12345678 → be 0010, wdata 0x78787878, we=1. SH addr 0x12 → be 1100, wdata 0x56785678.
- LW addr 0x102 → no bus_req; fault_out pulse with cause 01 in the next cycle. funct3=011 → cause 10. Both read and write asserted → cause 10.
- TIMEOUT_CYCLES=8, gnt never asserted → req high 8 cycles, then drops; fault cause 11; stall released.
- rst_n low during WAIT → outputs 0 immediately; a later rvalid is ignored; the next LW completes normally.
